// File: rtl/xc_malu_seq.sv
// xc_malu_seq: sequencer for the multi-cycle MALU datapath.
// Holds the count/acc/arg_0/arg_1 state and feeds it to a combinational
// datapath. Each busy cycle it registers the datapath's next-state values.
// It stops when the datapath reports a final result, or when the watchdog
// expires. Completion is a registered one-cycle ready pulse with the result
// and the timeout qualifier.
// MAX_CYCLES must be below 2**CNT_W, so that count never wraps.

module xc_malu_seq #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              valid,
  input  logic              flush,
  input  logic [31:0]       rs1,
  input  logic [31:0]       rs2,
  output logic [CNT_W-1:0]  count,
  output logic [63:0]       acc,
  output logic [31:0]       arg_0,
  output logic [31:0]       arg_1,
  input  logic [63:0]       n_acc,
  input  logic [31:0]       n_arg_0,
  input  logic [31:0]       n_arg_1,
  input  logic              dp_ready,
  input  logic [63:0]       dp_result,
  output logic [63:0]       result,
  output logic              ready,
  output logic              timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // This is the last busy step the watchdog allows before it forces completion.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_r,   state_nx_s;
  logic [CNT_W-1:0] count_r,   count_nx_s;
  logic [63:0]      acc_r,     acc_nx_s;
  logic [31:0]      arg_0_r,   arg_0_nx_s;
  logic [31:0]      arg_1_r,   arg_1_nx_s;
  logic [63:0]      result_r,  result_nx_s;
  logic             ready_r,   ready_nx_s;
  logic             timeout_r, timeout_nx_s;

  // Next-state logic: accept, step, abort, or complete the in-flight op.
  always_comb begin
    state_nx_s   = state_r;
    count_nx_s   = count_r;
    acc_nx_s     = acc_r;
    arg_0_nx_s   = arg_0_r;
    arg_1_nx_s   = arg_1_r;
    result_nx_s  = result_r;
    ready_nx_s   = 1'b0;
    timeout_nx_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (valid && !flush) begin
          state_nx_s = ST_BUSY;
          count_nx_s = CNT_ZERO;
          acc_nx_s   = 64'd0;
          arg_0_nx_s = rs1;
          arg_1_nx_s = 32'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (flush || !valid) begin
          // Abort: a dropped request behaves exactly like a flush.
          state_nx_s = ST_IDLE;
          count_nx_s = CNT_ZERO;
        end else if (dp_ready) begin
          state_nx_s  = ST_DONE;
          result_nx_s = dp_result;
          ready_nx_s  = 1'b1;
        end else if (count_r == CNT_LAST) begin
          // The watchdog expired, so complete the op with a zero result.
          state_nx_s   = ST_DONE;
          result_nx_s  = 64'd0;
          ready_nx_s   = 1'b1;
          timeout_nx_s = 1'b1;
        end else begin
          count_nx_s = count_r + CNT_ONE;
          acc_nx_s   = n_acc;
          arg_0_nx_s = n_arg_0;
          arg_1_nx_s = n_arg_1;
        end
      end

      ST_DONE: begin
        // ready is high in this cycle. valid and flush are ignored here.
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset clears everything, so no ready pulse follows.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      acc_r     <= 64'd0;
      arg_0_r   <= 32'd0;
      arg_1_r   <= 32'd0;
      result_r  <= 64'd0;
      ready_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      count_r   <= count_nx_s;
      acc_r     <= acc_nx_s;
      arg_0_r   <= arg_0_nx_s;
      arg_1_r   <= arg_1_nx_s;
      result_r  <= result_nx_s;
      ready_r   <= ready_nx_s;
      timeout_r <= timeout_nx_s;
    end
  end

  assign count   = count_r;
  assign acc     = acc_r;
  assign arg_0   = arg_0_r;
  assign arg_1   = arg_1_r;
  assign result  = result_r;
  assign ready   = ready_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Testbench for xc_malu_seq. The datapath is a small behavioural stub:
// - mul/mulu use repeated addition.
// - divu/remu use repeated subtraction.
// - the stuck op never raises dp_ready.
// A spec-level model predicts the outputs, and a negedge process compares them.
`timescale 1ns/1ps

module tb_xc_malu_seq;

  localparam int CNT_W      = 6;
  localparam int MAX_CYCLES = 40;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULU  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_REMU  = 3'd3;
  localparam logic [2:0] OP_STUCK = 3'd4;

  logic             clock  = 1'b0;
  logic             resetn = 1'b0;
  logic             valid  = 1'b0;
  logic             flush  = 1'b0;
  logic [31:0]      rs1    = 32'd0;
  logic [31:0]      rs2    = 32'd0;
  logic [2:0]       op     = OP_MUL;
  logic [CNT_W-1:0] count;
  logic [63:0]      acc;
  logic [31:0]      arg_0;
  logic [31:0]      arg_1;
  logic [63:0]      n_acc;
  logic [31:0]      n_arg_0;
  logic [31:0]      n_arg_1;
  logic             dp_ready;
  logic [63:0]      dp_result;
  logic [63:0]      result;
  logic             ready;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  xc_malu_seq #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clock(clock), .resetn(resetn), .valid(valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .count(count), .acc(acc), .arg_0(arg_0), .arg_1(arg_1),
    .n_acc(n_acc), .n_arg_0(n_arg_0), .n_arg_1(n_arg_1),
    .dp_ready(dp_ready), .dp_result(dp_result),
    .result(result), .ready(ready), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Stub datapath: combinational on the sequencer state and the operands.
  always_comb begin
    n_acc     = acc;
    n_arg_0   = arg_0;
    n_arg_1   = arg_1 + 32'd1;
    dp_ready  = 1'b0;
    dp_result = 64'hDEAD_BEEF_DEAD_BEEF;
    case (op)
      OP_MUL: begin
        dp_ready  = (arg_0 == 32'd0);
        n_acc     = acc + {{32{rs2[31]}}, rs2};
        n_arg_0   = arg_0 - 32'd1;
        dp_result = acc;
      end
      OP_MULU: begin
        dp_ready  = (arg_0 == 32'd0);
        n_acc     = acc + {32'd0, rs2};
        n_arg_0   = arg_0 - 32'd1;
        dp_result = acc;
      end
      OP_DIVU, OP_REMU: begin
        dp_ready  = (arg_0 < rs2);
        n_acc     = acc + 64'd1;
        n_arg_0   = arg_0 - rs2;
        dp_result = (op == OP_DIVU) ? acc : {32'd0, arg_0};
      end
      default: begin
        dp_ready = 1'b0;
      end
    endcase
  end

  // Expected result, from plain arithmetic.
  function automatic logic [63:0] res_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MUL:  return sa * sb;
      OP_MULU: return {32'd0, a} * {32'd0, b};
      OP_DIVU: return {32'd0, a / b};
      OP_REMU: return {32'd0, a % b};
      default: return 64'd0;
    endcase
  endfunction

  // Busy step index at which the stub reports a final result.
  function automatic int need_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_MUL, OP_MULU:  return int'(a);
      OP_DIVU, OP_REMU: return int'(a / b);
      default:          return 1000;
    endcase
  endfunction

  // Spec-level model: phase 0 = idle, 1 = busy, 2 = done.
  int          m_phase, m_count, m_need;
  logic [31:0] m_arg1;
  logic [63:0] m_pend, m_result;
  logic        m_ready, m_timeout;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase <= 0; m_count <= 0; m_need <= 0; m_arg1 <= 32'd0;
      m_pend <= 64'd0; m_result <= 64'd0; m_ready <= 1'b0; m_timeout <= 1'b0;
    end else begin
      m_ready   <= 1'b0;
      m_timeout <= 1'b0;
      case (m_phase)
        0: if (valid && !flush) begin
          m_phase <= 1; m_count <= 0; m_arg1 <= 32'd0;
          m_need <= need_of(op, rs1, rs2);
          m_pend <= res_of(op, rs1, rs2);
        end
        1: if (flush || !valid) begin
          m_phase <= 0; m_count <= 0;
        end else if (m_count == m_need) begin
          m_phase <= 2; m_result <= m_pend; m_ready <= 1'b1;
        end else if (m_count == MAX_CYCLES - 1) begin
          m_phase <= 2; m_result <= 64'd0; m_ready <= 1'b1; m_timeout <= 1'b1;
        end else begin
          m_count <= m_count + 1; m_arg1 <= m_arg1 + 32'd1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the inactive clock edge.
  always @(negedge clock) begin
    chk("ready",   64'(ready),   64'(m_ready));
    chk("timeout", 64'(timeout), 64'(m_timeout));
    chk("result",  result,       m_result);
    chk("count",   64'(count),   64'(m_count));
    chk("arg_1",   64'(arg_1),   64'(m_arg1));
    if (m_phase == 1 && m_count == 0) begin
      chk("accept_arg_0", 64'(arg_0), 64'(rs1));
      chk("accept_acc",   acc,        64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int steps);
    op = o; rs1 = a; rs2 = b; valid = 1'b1; flush = 1'b0;
    steps = 0;
    do begin
      step();
      steps++;
    end while (!ready && steps < 200);
    chk("ready_seen", 64'(ready), 64'd1);
  endtask

  task automatic wait_count(input int n);
    int k;
    k = 0;
    while (count != CNT_W'(n) && k < 100) begin
      step();
      k++;
    end
    chk("reach_count", 64'(count), 64'(n));
  endtask

  initial begin
    int s;
    step(); step(); step();
    chk("rst_ready",  64'(ready), 64'd0);
    chk("rst_result", result,     64'd0);
    chk("rst_count",  64'(count), 64'd0);
    resetn = 1'b1;
    step();

    // mul 7 * -3
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, s);
    chk("mul_lo",      64'(result[31:0]), 64'h0000_0000_FFFF_FFEB);
    chk("mul_timeout", 64'(timeout),      64'd0);
    chk("mul_steps",   64'(s),            64'd9);
    valid = 1'b0;
    step();
    chk("mul_one_pulse", 64'(ready), 64'd0);

    // divu then remu back to back. valid stays high through the ready cycle.
    run_op(OP_DIVU, 32'd100, 32'd7, s);
    chk("divu", result, 64'd14);
    run_op(OP_REMU, 32'd100, 32'd7, s);
    chk("remu",       result,    64'd2);
    chk("remu_steps", 64'(s),    64'd17);
    valid = 1'b0;
    step();

    // watchdog
    run_op(OP_STUCK, 32'd5, 32'd5, s);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_result",  result,       64'd0);
    chk("wd_steps",   64'(s),       64'd41);
    chk("wd_count",   64'(count),   64'd39);
    valid = 1'b0;
    step();
    chk("wd_timeout_drop", 64'(timeout), 64'd0);

    // flush at count 5, then mulu 3*5
    op = OP_MULU; rs1 = 32'd20; rs2 = 32'd2; valid = 1'b1;
    wait_count(5);
    flush = 1'b1;
    step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(ready), 64'd0);
    flush = 1'b0; valid = 1'b0;
    step();
    chk("flush_ready2", 64'(ready), 64'd0);
    run_op(OP_MULU, 32'd3, 32'd5, s);
    chk("mulu_3x5", result, 64'd15);
    valid = 1'b0;
    step();

    // asynchronous reset pulse mid-BUSY
    op = OP_MULU; rs1 = 32'd30; rs2 = 32'd1; valid = 1'b1;
    repeat (6) step();
    #1;
    resetn = 1'b0;
    #0.5;
    chk("arst_count",   64'(count),   64'd0);
    chk("arst_acc",     acc,          64'd0);
    chk("arst_arg_0",   64'(arg_0),   64'd0);
    chk("arst_arg_1",   64'(arg_1),   64'd0);
    chk("arst_result",  result,       64'd0);
    chk("arst_ready",   64'(ready),   64'd0);
    chk("arst_timeout", 64'(timeout), 64'd0);
    #0.5;
    resetn = 1'b1;
    valid  = 1'b0;
    step();
    chk("arst_no_ready", 64'(ready), 64'd0);
    run_op(OP_MULU, 32'd6, 32'd7, s);
    chk("mulu_6x7", result, 64'd42);
    valid = 1'b0;
    step();

    // valid dropped at count 3
    op = OP_MULU; rs1 = 32'd20; rs2 = 32'd2; valid = 1'b1;
    wait_count(3);
    valid = 1'b0;
    step();
    chk("vdrop_ready", 64'(ready), 64'd0);
    chk("vdrop_count", 64'(count), 64'd0);
    step();
    chk("vdrop_ready2", 64'(ready), 64'd0);
    run_op(OP_MULU, 32'd2, 32'd9, s);
    chk("mulu_2x9", result, 64'd18);
    valid = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
